// File: rtl/core_pkg.sv
// Shared core types: register-file widths, ROB tag type and commit bus.
package core_pkg;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int NREG  = 32;

  typedef logic [TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                    valid;
    logic [$clog2(NREG)-1:0] rd;
    rob_tag_t                tag;
    logic [XLEN-1:0]         data;
  } commit_bus;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port.
// With REGFILE_COMMIT_BYPASS_EN, forwards a same-cycle owning commit.
module regfile_read_port
  import core_pkg::*;
#(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int NREG     = core_pkg::NREG,
  parameter int TAG_W    = core_pkg::TAG_W,
  parameter int COMMIT_W = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic [AW-1:0]          addr,
  input  logic [XLEN-1:0]        data_q [NREG],
  input  logic [NREG-1:0]        busy_q,
  input  logic [TAG_W-1:0]       tag_q [NREG],
  input  logic                   flush,
  input  logic [COMMIT_W-1:0]    cm_valid,
  input  logic [COMMIT_W*AW-1:0] cm_rd,
  input  logic [COMMIT_W*TAG_W-1:0] cm_tag,
  input  logic [COMMIT_W*XLEN-1:0]  cm_data,
  output logic [XLEN-1:0]        data,
  output logic                   busy,
  output logic [TAG_W-1:0]       tag
);

  logic            live;
  logic [XLEN-1:0] st_data;
  logic            st_busy;
  logic [TAG_W-1:0] st_tag;

  assign live = (addr != '0) && (int'(addr) < NREG);

  always_comb begin
    st_data = '0;
    st_busy = 1'b0;
    st_tag  = '0;
    if (live) begin
      st_data = data_q[addr];
      st_busy = busy_q[addr];
      st_tag  = tag_q[addr];
    end
  end

`ifdef REGFILE_COMMIT_BYPASS_EN
  always_comb begin
    data = st_data;
    busy = st_busy;
    tag  = st_tag;
    // Later ports are younger, so the last hit overrides.
    for (int k = 0; k < COMMIT_W; k++) begin
      if (!flush && cm_valid[k] && live && st_busy &&
          cm_rd[k*AW +: AW] == addr &&
          cm_tag[k*TAG_W +: TAG_W] == st_tag) begin
        data = cm_data[k*XLEN +: XLEN];
        busy = 1'b0;
      end
    end
  end
`else
  logic unused_cm;
  assign unused_cm = ^{flush, cm_valid, cm_rd, cm_tag, cm_data};
  assign data = st_data;
  assign busy = st_busy;
  assign tag  = st_tag;
`endif

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with busy/ROB-tag rename state.
// Optional same-cycle commit forwarding: REGFILE_COMMIT_BYPASS_EN.
module rename_regfile
  import core_pkg::*;
#(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int NREG     = core_pkg::NREG,
  parameter int TAG_W    = core_pkg::TAG_W,
  parameter int NUM_RD   = 2,
  parameter int COMMIT_W = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic [NUM_RD*AW-1:0]      rd_addr,
  output logic [NUM_RD*XLEN-1:0]    rd_data,
  output logic [NUM_RD-1:0]         rd_busy,
  output logic [NUM_RD*TAG_W-1:0]   rd_tag,
  input  logic                      ren_valid,
  input  logic [AW-1:0]             ren_rd,
  input  logic [TAG_W-1:0]          ren_tag,
  input  logic [COMMIT_W-1:0]       cm_valid,
  input  logic [COMMIT_W*AW-1:0]    cm_rd,
  input  logic [COMMIT_W*TAG_W-1:0] cm_tag,
  input  logic [COMMIT_W*XLEN-1:0]  cm_data
);

  logic [XLEN-1:0]  data_q [NREG];
  logic [NREG-1:0]  busy_q;
  logic [TAG_W-1:0] tag_q [NREG];

  function automatic logic wr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy_q <= '0;
      end else begin
        // Ascending order: younger port's data write lands last.
        for (int k = 0; k < COMMIT_W; k++) begin
          if (cm_valid[k] && wr_ok(cm_rd[k*AW +: AW])) begin
            data_q[cm_rd[k*AW +: AW]] <= cm_data[k*XLEN +: XLEN];
            if (busy_q[cm_rd[k*AW +: AW]] &&
                tag_q[cm_rd[k*AW +: AW]] == cm_tag[k*TAG_W +: TAG_W])
              busy_q[cm_rd[k*AW +: AW]] <= 1'b0;
          end
        end
        // A new producer overrides any same-cycle busy clear.
        if (ren_valid && wr_ok(ren_rd)) begin
          busy_q[ren_rd] <= 1'b1;
          tag_q[ren_rd]  <= ren_tag;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_read_port #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .TAG_W    (TAG_W),
      .COMMIT_W (COMMIT_W),
      .AW       (AW)
    ) u_port (
      .addr     (rd_addr[p*AW +: AW]),
      .data_q   (data_q),
      .busy_q   (busy_q),
      .tag_q    (tag_q),
      .flush    (flush),
      .cm_valid (cm_valid),
      .cm_rd    (cm_rd),
      .cm_tag   (cm_tag),
      .cm_data  (cm_data),
      .data     (rd_data[p*XLEN +: XLEN]),
      .busy     (rd_busy[p]),
      .tag      (rd_tag[p*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: directed plan plus random traffic.
// Build with REGFILE_COMMIT_BYPASS_EN to expect same-cycle forwarding.
module tb_rename_regfile;

  logic        clk = 0;
  logic        rst, rdy, flush;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [7:0]  rd_tag;
  logic        ren_valid;
  logic [4:0]  ren_rd;
  logic [3:0]  ren_tag;
  logic [0:0]  cm_valid;
  logic [4:0]  cm_rd;
  logic [3:0]  cm_tag;
  logic [31:0] cm_data;

  rename_regfile dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .rd_tag(rd_tag),
    .ren_valid(ren_valid), .ren_rd(ren_rd), .ren_tag(ren_tag),
    .cm_valid(cm_valid), .cm_rd(cm_rd),
    .cm_tag(cm_tag), .cm_data(cm_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [4:0]  addr;
    logic [31:0] d;
    logic        b;
    logic [3:0]  t;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  logic [31:0] m_data [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];

  function automatic exp_t predict(int p, logic [4:0] a);
    exp_t e;
    e.port = p;
    e.addr = a;
    e.d = (a == 0) ? 32'h0 : m_data[a];
    e.b = (a == 0) ? 1'b0 : m_busy[a];
    e.t = (a == 0) ? 4'h0 : m_tag[a];
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (!flush && cm_valid[0] && a != 0 && cm_rd == a &&
        m_busy[a] && m_tag[a] == cm_tag) begin
      e.d = cm_data;
      e.b = 1'b0;
    end
`endif
    return e;
  endfunction

  task automatic model_edge();
    bit owner;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_data[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
      end
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else begin
        owner = cm_valid[0] && cm_rd != 0 &&
                m_busy[cm_rd] && m_tag[cm_rd] == cm_tag;
        if (cm_valid[0] && cm_rd != 0) m_data[cm_rd] = cm_data;
        if (owner) m_busy[cm_rd] = 0;
        if (ren_valid && ren_rd != 0) begin
          m_busy[ren_rd] = 1;
          m_tag[ren_rd] = ren_tag;
        end
      end
    end
  endtask

  task automatic step(
    input logic r, input logic en, input logic fl,
    input logic rv, input logic [4:0] rr, input logic [3:0] rt,
    input logic cv, input logic [4:0] cr, input logic [3:0] ct,
    input logic [31:0] cd,
    input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    rst = r; rdy = en; flush = fl;
    ren_valid = rv; ren_rd = rr; ren_tag = rt;
    cm_valid = cv; cm_rd = cr; cm_tag = ct; cm_data = cd;
    rd_addr = {a1, a0};
    q.push_back(predict(0, a0));
    q.push_back(predict(1, a1));
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle_read(input logic [4:0] a0, input logic [4:0] a1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  // Monitor: reads are always presented, compare mid-cycle.
  initial begin
    exp_t e;
    logic [31:0] gd;
    logic        gb;
    logic [3:0]  gt;
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        e = q.pop_front();
        gd = rd_data[e.port*32 +: 32];
        gb = rd_busy[e.port];
        gt = rd_tag[e.port*4 +: 4];
        checks++;
        if (gd !== e.d || gb !== e.b || gt !== e.t) begin
          failures++;
          $display("FAIL read_p%0d x%0d got d=%h b=%b t=%0d want d=%h b=%b t=%0d",
                   e.port, e.addr, gd, gb, gt, e.d, e.b, e.t);
        end
      end
    end
  end

  task automatic rand_step();
    logic r, en, fl, rv, cv;
    logic [4:0] rr, cr, a0, a1;
    logic [3:0] rt, ct;
    logic [31:0] cd;
    int start;
    r  = ($urandom_range(0, 199) == 0);
    en = ($urandom_range(0, 9) != 0);
    fl = ($urandom_range(0, 29) == 0);
    rv = $urandom_range(0, 9) < 6;
    rr = 5'($urandom_range(0, 31));
    rt = 4'($urandom);
    cv = $urandom_range(0, 9) < 6;
    cr = 5'($urandom_range(0, 31));
    ct = 4'($urandom);
    cd = $urandom;
    if ($urandom_range(0, 9) < 7) begin
      start = $urandom_range(0, 31);
      for (int i = 0; i < 32; i++)
        if (m_busy[(start + i) % 32]) begin
          cr = 5'((start + i) % 32);
          break;
        end
      if ($urandom_range(0, 9) < 7) ct = m_tag[cr];
    end
    if (fl) cv = 0;
    a0 = ($urandom_range(0, 1) == 1) ? cr : 5'($urandom_range(0, 31));
    a1 = ($urandom_range(0, 2) == 0) ? rr : 5'($urandom_range(0, 31));
    step(r, en, fl, rv, rr, rt, cv, cr, ct, cd, a0, a1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1; rdy = 1; flush = 0; rd_addr = 0;
    ren_valid = 0; ren_rd = 0; ren_tag = 0;
    cm_valid = 0; cm_rd = 0; cm_tag = 0; cm_data = 0;
    for (int i = 0; i < 32; i++) begin
      m_data[i] = 32'hx; m_busy[i] = 0; m_tag[i] = 4'hx;
    end
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 32; i += 2) idle_read(5'(i), 5'(i + 1));
    // rename then owning commit
    step(0, 1, 0, 1, 5, 3, 0, 0, 0, 0, 5, 5);
    step(0, 1, 0, 0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 5, 5);
    idle_read(5, 5);
    // stale commit after re-rename
    step(0, 1, 0, 1, 7, 2, 0, 0, 0, 0, 7, 0);
    step(0, 1, 0, 1, 7, 6, 0, 0, 0, 0, 7, 0);
    step(0, 1, 0, 0, 0, 0, 1, 7, 2, 32'h11, 7, 7);
    idle_read(7, 7);
    step(0, 1, 0, 0, 0, 0, 1, 7, 6, 32'h22, 7, 7);
    idle_read(7, 7);
    // rename and old-owner commit in the same cycle
    step(0, 1, 0, 1, 9, 1, 0, 0, 0, 0, 9, 0);
    step(0, 1, 0, 1, 9, 4, 1, 9, 1, 32'h55, 9, 9);
    idle_read(9, 9);
    // flush ignores commit/rename, rdy=0 freezes
    step(0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 3, 0);
    step(0, 1, 0, 1, 4, 2, 0, 0, 0, 0, 4, 3);
    step(0, 1, 0, 1, 10, 3, 0, 0, 0, 0, 10, 4);
    step(0, 1, 1, 1, 11, 5, 1, 3, 1, 32'h99, 3, 4);
    idle_read(3, 4);
    idle_read(10, 11);
    step(0, 0, 0, 1, 8, 7, 1, 3, 1, 32'h77, 8, 3);
    idle_read(8, 3);
    // same-cycle commit visibility
    step(0, 1, 0, 1, 12, 5, 0, 0, 0, 0, 12, 0);
    step(0, 1, 0, 0, 0, 0, 1, 12, 5, 32'hABCD, 12, 12);
    idle_read(12, 12);
    // x0 is immutable
    step(0, 1, 0, 1, 0, 1, 1, 0, 0, 32'hFFFF_FFFF, 0, 0);
    idle_read(0, 0);
    for (int n = 0; n < 1500; n++) rand_step();
    idle_read(1, 2);
    @(negedge clk);
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    #5;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file with per-register rename status (busy bit plus ROB tag) for the out-of-order core.
- Sits between the instruction queue/dispatch stage and the ROB.
- Dispatch reads operand values or producer tags on NUM_RD read ports and renames one destination per cycle.
- The ROB retires up to COMMIT_W results per cycle. Busy clears only when the committing tag matches the current owner tag.

Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers; register 0 is hardwired zero
- TAG_W, 4, ROB tag width
- NUM_RD, 2, number of combinational read ports
- COMMIT_W, 1, number of commit ports; a higher index means a younger instruction
- AW, $clog2(NREG), derived register-index width, not overridable

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- flush  in  1  mispredict flush; clears all busy bits
- rd_addr  in  NUM_RD*AW  packed read indices
- rd_data  out  NUM_RD*XLEN  register values
- rd_busy  out  NUM_RD  register awaits a producer
- rd_tag  out  NUM_RD*TAG_W  owning ROB tag (valid when busy)
- ren_valid  in  1  rename request
- ren_rd  in  AW  destination register
- ren_tag  in  TAG_W  ROB tag of the new producer
- cm_valid  in  COMMIT_W  commit request per port
- cm_rd  in  COMMIT_W*AW  commit destination
- cm_tag  in  COMMIT_W*TAG_W  ROB tag of the committing entry
- cm_data  in  COMMIT_W*XLEN  result value

Behaviour:
- State per register: data[XLEN], busy, tag[TAG_W].
- Reset (rst=1 at posedge): all data=0, busy=0, tag=0. Read outputs are combinational from state, so every read returns data=0, busy=0, tag=0 after reset.
- Priority at posedge: rst > !rdy (hold everything) > flush > normal update.
- Flush cycle: all busy cleared to 0. Data and tag are unchanged. Any cm_valid and ren_valid in that cycle are ignored. The ROB must not commit during a flush.
- Normal cycle, commit handling for each port k with cm_valid[k] and cm_rd[k]!=0:
  - data[cm_rd[k]] <= cm_data[k] unconditionally.
  - busy is cleared only if busy=1 and tag==cm_tag[k]; otherwise busy and tag are unchanged (the register was re-renamed by a younger instruction).
- Normal cycle, rename handling: if ren_valid and ren_rd!=0, busy[ren_rd]<=1 and tag[ren_rd]<=ren_tag.
- Rename beats a commit clear to the same register in the same cycle. The commit data write still happens.
- Two commit ports writing the same rd in one cycle: the higher port index wins for data. Busy clears if either port's tag matches.
- Register 0: writes and renames are dropped, and it always reads data=0, busy=0, tag=0.
- Read latency: combinational, zero cycles. Reads reflect state before the current edge, so a same-cycle rename is not visible. Dispatch resolves dependencies inside its own group.
- Indices with rd_addr >= NREG return 0, not busy (relevant only when NREG is not a power of two).

Optional Feature:
- Macro: REGFILE_COMMIT_BYPASS_EN.
- Defined: each read port forwards a same-cycle commit. If cm_valid[k], cm_rd[k]==rd_addr!=0, busy=1 and tag==cm_tag[k], the port outputs rd_data=cm_data[k] and rd_busy=0. The highest matching k wins.
- Undefined: reads return stored state only, and the committed value becomes visible one cycle later.
- State update is identical in both builds. Forwarding is suppressed when flush=1.

Decomposition:
- Shared package core_pkg holds XLEN, TAG_W, the NREG default, the rob_tag_t typedef, and the commit_bus struct {valid, rd, tag, data}.
- One natural sub-module: regfile_read_port, a single read mux plus the optional bypass compare, instantiated NUM_RD times via generate.

Test Plan:
1. Reset, then read x1..x31 -> data=0, busy=0 on every port.
2. Rename x5 tag 3; next cycle commit x5 tag 3 data 0xDEADBEEF -> after the commit edge, x5 busy=0 and data=0xDEADBEEF.
3. Rename x7 tag 2, then rename x7 tag 6, then commit x7 tag 2 data 0x11 -> data=0x11, busy=1, tag=6. Then commit tag 6 data 0x22 -> busy=0, data=0x22.
4. Same cycle: rename x9 tag 4 and commit x9 tag 1 (old owner, busy) data 0x55 -> data=0x55, busy=1, tag=4.
5. Rename x3, x4 and x10, then flush with cm_valid=1 on x3 -> all busy=0 and x3 data unchanged. With rdy=0 and a rename on x8 -> no state change.
6. Bypass build, x12 busy tag 5, same-cycle commit x12 tag 5 data 0xABCD -> read port shows 0xABCD, busy=0 in that cycle. Non-bypass build shows busy=1 until the next cycle. Writes, renames and commits to x0 leave it reading 0.
